// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encoding and fetch constants.
package fetch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_HOLD = 2'd3;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

endpackage

// File: rtl/fetch_hold_reg.sv
// One-entry {pc,instr} holding register presented to decode.
// A drop leaves a NOP in the instruction slot.
module fetch_hold_reg
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic            consume_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear_i) begin
      valid_d = 1'b0;
      instr_d = XLEN'(INSTR_NOP);
    end else if (consume_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC, single-outstanding IMEM handshake, redirects.
// Define FETCH_CTRL_PERF_EN to build the fetch/redirect counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCSrc_in,
  input  logic [XLEN-1:0] PCimm_in,
  input  logic            id_ready_in,
  input  logic            imem_gnt_in,
  input  logic            imem_rvalid_in,
  input  logic [XLEN-1:0] imem_rdata_in,
  output logic            imem_req_out,
  output logic [XLEN-1:0] imem_addr_out,
  output logic            if_valid_out,
  output logic [XLEN-1:0] if_pc_out,
  output logic [XLEN-1:0] if_instr_out,
  output logic [31:0]     fetch_cnt_out,
  output logic [31:0]     redir_cnt_out
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic            hold_load, hold_clear, hold_consume;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] issued_pc;

  assign target = {PCimm_in[XLEN-1:2], 2'b00};
  // Without a pending kill, pc has advanced exactly once since the grant.
  assign issued_pc = pc_q - XLEN'(PC_STEP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    hold_load    = 1'b0;
    hold_clear   = 1'b0;
    hold_consume = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (PCSrc_in) pc_d = target;
      end
      ST_REQ: begin
        if (imem_gnt_in) begin
          state_d = ST_WAIT;
          kill_d  = PCSrc_in;
          pc_d    = PCSrc_in ? target
                             : pc_q + XLEN'(PC_STEP);
        end else if (PCSrc_in) begin
          pc_d = target;
        end
      end
      ST_WAIT: begin
        if (PCSrc_in) pc_d = target;
        if (imem_rvalid_in) begin
          kill_d  = 1'b0;
          state_d = ST_REQ;
          if (!kill_q && !PCSrc_in) begin
            hold_load = 1'b1;
            state_d   = ST_HOLD;
          end
        end else if (PCSrc_in) begin
          kill_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (PCSrc_in) begin
          hold_clear = 1'b1;
          pc_d       = target;
          state_d    = ST_REQ;
        end else if (id_ready_in) begin
          hold_consume = 1'b1;
          state_d      = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req_out  = (state_q == ST_REQ);
    imem_addr_out = pc_q;
  end

  fetch_hold_reg #(
    .XLEN (XLEN)
  ) u_hold (
    .clk       (clk),
    .rst_n     (reset),
    .load_i    (hold_load),
    .clear_i   (hold_clear),
    .consume_i (hold_consume),
    .pc_i      (issued_pc),
    .instr_i   (imem_rdata_in),
    .valid_o   (if_valid_out),
    .pc_o      (if_pc_out),
    .instr_o   (if_instr_out)
  );

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] redir_cnt_q, redir_cnt_d;

  // A redirect racing id_ready still retires the held instruction.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (state_q == ST_HOLD && id_ready_in)
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (PCSrc_in)
      redir_cnt_d = redir_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign fetch_cnt_out = fetch_cnt_q;
  assign redir_cnt_out = redir_cnt_q;
`else
  assign fetch_cnt_out = 32'h0;
  assign redir_cnt_out = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a
// randomized run against a transaction-level fetch model.
module tb_fetch_ctrl;

`ifdef FETCH_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        PCSrc_in = 1'b0;
  logic [31:0] PCimm_in = '0;
  logic        id_ready_in = 1'b0;
  logic        imem_gnt_in = 1'b0;
  logic        imem_rvalid_in = 1'b0;
  logic [31:0] imem_rdata_in = '0;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        if_valid_out;
  logic [31:0] if_pc_out;
  logic [31:0] if_instr_out;
  logic [31:0] fetch_cnt_out;
  logic [31:0] redir_cnt_out;

  int nchk = 0;
  int nfail = 0;

  fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .PCSrc_in       (PCSrc_in),
    .PCimm_in       (PCimm_in),
    .id_ready_in    (id_ready_in),
    .imem_gnt_in    (imem_gnt_in),
    .imem_rvalid_in (imem_rvalid_in),
    .imem_rdata_in  (imem_rdata_in),
    .imem_req_out   (imem_req_out),
    .imem_addr_out  (imem_addr_out),
    .if_valid_out   (if_valid_out),
    .if_pc_out      (if_pc_out),
    .if_instr_out   (if_instr_out),
    .fetch_cnt_out  (fetch_cnt_out),
    .redir_cnt_out  (redir_cnt_out)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic g, input logic rv,
                     input logic rdy, input logic src,
                     input logic [31:0] imm,
                     input logic [31:0] rd);
    imem_gnt_in    = g;
    imem_rvalid_in = rv;
    id_ready_in    = rdy;
    PCSrc_in       = src;
    PCimm_in       = imm;
    imem_rdata_in  = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    nchk++;
    if ({imem_req_out, imem_addr_out, if_valid_out,
         if_pc_out, if_instr_out} !== '0) begin
      nfail++;
      $display("FAIL reset_outs req=%0b addr=%h v=%0b pc=%h ins=%h, want all 0",
               imem_req_out, imem_addr_out, if_valid_out,
               if_pc_out, if_instr_out);
    end
    nchk++;
    if ({fetch_cnt_out, redir_cnt_out} !== '0) begin
      nfail++;
      $display("FAIL reset_cnt got %h/%h want 0/0",
               fetch_cnt_out, redir_cnt_out);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    nchk++;
    if (imem_req_out !== 1'b0) begin
      nfail++;
      $display("FAIL idle_req got %0b want 0", imem_req_out);
    end
    cyc(0, 0, 0, 0, 0, 0);
    nchk++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h0) begin
      nfail++;
      $display("FAIL first_req got req=%0b addr=%h want 1/0",
               imem_req_out, imem_addr_out);
    end
  endtask

  task automatic test_fetch_seq();
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      d = 32'hA5A5_0000 + 32'(i);
      nchk++;
      if (imem_req_out !== 1'b1 || imem_addr_out !== 32'(4 * i)) begin
        nfail++;
        $display("FAIL seq_req%0d got req=%0b addr=%h want 1/%h",
                 i, imem_req_out, imem_addr_out, 4 * i);
      end
      cyc(1, 0, 1, 0, 0, 0);
      nchk++;
      if (imem_req_out !== 1'b0 || if_valid_out !== 1'b0) begin
        nfail++;
        $display("FAIL seq_wait%0d got req=%0b v=%0b want 0/0",
                 i, imem_req_out, if_valid_out);
      end
      cyc(0, 1, 1, 0, 0, d);
      nchk++;
      if (if_valid_out !== 1'b1 || if_pc_out !== 32'(4 * i) ||
          if_instr_out !== d) begin
        nfail++;
        $display("FAIL seq_out%0d got v=%0b pc=%h ins=%h want 1/%h/%h",
                 i, if_valid_out, if_pc_out, if_instr_out, 4 * i, d);
      end
      cyc(0, 0, 1, 0, 0, 0);
    end
  endtask

  task automatic test_stall();
    do_reset();
    cyc(1, 0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 32'h1234);
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0, 0, 0);
      nchk++;
      if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h4) begin
        nfail++;
        $display("FAIL stall%0d got req=%0b addr=%h want 1/4",
                 i, imem_req_out, imem_addr_out);
      end
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    cyc(1, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'h2C, 0);
    cyc(0, 1, 1, 0, 0, 32'hDEAD_BEEF);
    nchk++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h2C ||
        if_valid_out !== 1'b0) begin
      nfail++;
      $display("FAIL rdw_req got req=%0b addr=%h v=%0b want 1/2c/0",
               imem_req_out, imem_addr_out, if_valid_out);
    end
    cyc(1, 0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 32'h0000_1111);
    nchk++;
    if (if_valid_out !== 1'b1 || if_pc_out !== 32'h2C ||
        if_instr_out !== 32'h1111) begin
      nfail++;
      $display("FAIL rdw_out got v=%0b pc=%h ins=%h want 1/2c/1111",
               if_valid_out, if_pc_out, if_instr_out);
    end
  endtask

  task automatic test_hold_redirect();
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 32'hCAFE_0001);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      nchk++;
      if (if_valid_out !== 1'b1 || if_pc_out !== 32'h0 ||
          if_instr_out !== 32'hCAFE_0001 || imem_req_out !== 1'b0) begin
        nfail++;
        $display("FAIL hold%0d got v=%0b pc=%h ins=%h req=%0b",
                 i, if_valid_out, if_pc_out, if_instr_out, imem_req_out);
      end
    end
    cyc(0, 0, 0, 1, 32'h1E8, 0);
    nchk++;
    if (if_valid_out !== 1'b0 || imem_req_out !== 1'b1 ||
        imem_addr_out !== 32'h1E8) begin
      nfail++;
      $display("FAIL hold_redir got v=%0b req=%0b addr=%h want 0/1/1e8",
               if_valid_out, imem_req_out, imem_addr_out);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(1, 0, 1, 0, 0, 0);
    reset = 1'b0;
    #1;
    nchk++;
    if ({imem_req_out, imem_addr_out, if_valid_out,
         if_pc_out, if_instr_out} !== '0) begin
      nfail++;
      $display("FAIL rstmid got req=%0b addr=%h v=%0b pc=%h ins=%h",
               imem_req_out, imem_addr_out, if_valid_out,
               if_pc_out, if_instr_out);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(0, 1, 1, 0, 0, 32'hBAD0_BAD0);
    cyc(0, 1, 1, 0, 0, 32'hBAD0_BAD0);
    nchk++;
    if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h0 ||
        if_valid_out !== 1'b0) begin
      nfail++;
      $display("FAIL rstmid_restart got req=%0b addr=%h v=%0b want 1/0/0",
               imem_req_out, imem_addr_out, if_valid_out);
    end
  endtask

  task automatic test_counters();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 1, 0, 0, 0);
      cyc(0, 1, 1, 0, 0, 32'(i));
      cyc(0, 0, 1, 0, 0, 0);
    end
    cyc(0, 0, 1, 1, 32'h12, 0);
    nchk++;
    if (imem_addr_out !== 32'h10) begin
      nfail++;
      $display("FAIL cnt_addr got %h want 10", imem_addr_out);
    end
    nchk++;
    if (fetch_cnt_out !== (PERF ? 32'd5 : 32'd0) ||
        redir_cnt_out !== (PERF ? 32'd1 : 32'd0)) begin
      nfail++;
      $display("FAIL cnt_vals got %0d/%0d want %0d/%0d",
               fetch_cnt_out, redir_cnt_out,
               PERF ? 5 : 0, PERF ? 1 : 0);
    end
  endtask

  // Model: which request may issue, what it fetches, which
  // responses survive redirects, and what decode sees.
  task automatic test_random();
    logic [31:0] exp_pc, o_addr, o_data, h_pc, h_ins, tgt;
    bit o_v, o_k, h_v, g, rv, rdy, src, want_req;
    int unsigned ef, er, deliv;
    exp_pc = 0; o_addr = 0; o_data = 0; h_pc = 0; h_ins = 0;
    o_v = 0; o_k = 0; h_v = 0; ef = 0; er = 0; deliv = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      want_req = !o_v && !h_v;
      nchk++;
      if (imem_req_out !== want_req ||
          (want_req && imem_addr_out !== exp_pc)) begin
        nfail++;
        $display("FAIL rnd_req c=%0d got %0b/%h want %0b/%h",
                 c, imem_req_out, imem_addr_out, want_req, exp_pc);
      end
      nchk++;
      if (if_valid_out !== h_v ||
          (h_v && (if_pc_out !== h_pc || if_instr_out !== h_ins))) begin
        nfail++;
        $display("FAIL rnd_out c=%0d got %0b/%h/%h want %0b/%h/%h",
                 c, if_valid_out, if_pc_out, if_instr_out,
                 h_v, h_pc, h_ins);
      end
      nchk++;
      if (fetch_cnt_out !== (PERF ? 32'(ef) : 32'd0) ||
          redir_cnt_out !== (PERF ? 32'(er) : 32'd0)) begin
        nfail++;
        $display("FAIL rnd_cnt c=%0d got %0d/%0d want %0d/%0d",
                 c, fetch_cnt_out, redir_cnt_out,
                 PERF ? ef : 0, PERF ? er : 0);
      end
      g   = 1'($urandom_range(0, 1));
      rdy = 1'($urandom_range(0, 1));
      src = ($urandom_range(0, 7) == 0);
      tgt = $urandom;
      rv  = o_v && ($urandom_range(0, 2) == 0);
      imem_gnt_in    = g;
      imem_rvalid_in = rv;
      id_ready_in    = rdy;
      PCSrc_in       = src;
      PCimm_in       = tgt;
      imem_rdata_in  = rv ? o_data : $urandom;
      if (h_v && rdy) ef++;
      if (src) er++;
      if (want_req && g) begin
        o_v = 1; o_k = src; o_addr = exp_pc; o_data = $urandom;
      end else if (o_v && rv) begin
        o_v = 0;
        if (!o_k && !src) begin
          h_v = 1; h_pc = o_addr; h_ins = o_data;
        end
      end else if (o_v && src) begin
        o_k = 1;
      end else if (h_v && (src || rdy)) begin
        h_v = 0;
        if (rdy) deliv++;
      end
      if (src) exp_pc = {tgt[31:2], 2'b00};
      else if (want_req && g) exp_pc = exp_pc + 32'd4;
      @(posedge clk);
      #1;
    end
    nchk++;
    if (deliv < 10) begin
      nfail++;
      $display("FAIL rnd_progress got %0d deliveries want >=10", deliv);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_seq();
    test_stall();
    test_redirect_wait();
    test_hold_redirect();
    test_reset_mid();
    test_counters();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end

endmodule
